ofdm_cp_remover: RTL and testbench

OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

---
 rtl/ofdm_cp_remover_if.sv | 15 +
 rtl/ofdm_cp_remover.sv | 254 +++++++++++++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_remover_if.sv
// Avalon-ST beat bundle (data/valid/ready/sop/eop/error) shared by the
// cyclic-prefix remover's sink and source sides.
interface ofdm_cp_remover_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic              err;

  modport source (output data, valid, sop, eop, err, input ready);
  modport sink   (input data, valid, sop, eop, err, output ready);
endinterface

// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: drops cp_len leading beats per symbol, forwards NFFT.
// Optional macro OFDM_CP_REMOVER_STATS_EN adds good-symbol / error counters.
module ofdm_cp_remover_core #(
  parameter int DATA_W = 32,
  parameter int NFFT   = 32,
  parameter int CP_MAX = 8,
  parameter int CPW    = $clog2(CP_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CPW-1:0]   cfg_cp_len_i,
  ofdm_cp_remover_if.sink   in_s,
  ofdm_cp_remover_if.source out_s,
  output logic             len_err_o
`ifdef OFDM_CP_REMOVER_STATS_EN
  ,
  output logic [15:0]      sym_cnt_o,
  output logic [15:0]      err_cnt_o
`endif
);
  localparam int PW = $clog2(NFFT);
  localparam logic [CPW-1:0] CP_MAX_L = CPW'(CP_MAX);
  localparam logic [PW-1:0]  PAY_LAST = PW'(NFFT - 1);

  typedef enum logic [1:0] {IDLE, CP_SKIP, PAYLOAD, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } beat_t;

  state_t         state_q, state_d, phase;
  logic [CPW-1:0] cp_len_q, cp_len_d, cp_cnt_q, cp_cnt_d;
  logic [CPW-1:0] cp_eff, cp_cur, cp_pos;
  logic [PW-1:0]  pay_cnt_q, pay_cnt_d, pay_pos;
  logic           acc, fwd, good_sym;
  logic           len_err_q, len_err_d;
  beat_t          fwd_beat;

  beat_t          buf_q [2];
  beat_t          buf_d [2];
  logic [1:0]     cnt_q, cnt_d;
  logic           ready_q, pop;

  // An SOP beat re-bases the symbol before it is classified, so a restart
  // from any state is handled by the same CP/payload logic as a fresh start.
  always_comb begin
    acc       = in_s.valid & ready_q;
    cp_eff    = (cfg_cp_len_i > CP_MAX_L) ? CP_MAX_L : cfg_cp_len_i;
    state_d   = state_q;
    cp_len_d  = cp_len_q;
    cp_cnt_d  = cp_cnt_q;
    pay_cnt_d = pay_cnt_q;
    len_err_d = 1'b0;
    fwd       = 1'b0;
    good_sym  = 1'b0;
    fwd_beat  = '{data: in_s.data, sop: 1'b0, eop: 1'b0, err: in_s.err};
    phase     = state_q;
    cp_cur    = cp_len_q;
    cp_pos    = cp_cnt_q;
    pay_pos   = pay_cnt_q;

    if (acc && in_s.sop) begin
      if (state_q != IDLE) len_err_d = 1'b1;
      cp_cur   = cp_eff;
      cp_len_d = cp_eff;
      cp_pos   = '0;
      pay_pos  = '0;
      phase    = (cp_eff == '0) ? PAYLOAD : CP_SKIP;
    end

    if (acc) begin
      case (phase)
        IDLE: state_d = IDLE;
        CP_SKIP: begin
          if (in_s.eop) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else if (cp_pos + CPW'(1) == cp_cur) begin
            state_d   = PAYLOAD;
            pay_cnt_d = '0;
          end else begin
            state_d  = CP_SKIP;
            cp_cnt_d = cp_pos + CPW'(1);
          end
        end
        PAYLOAD: begin
          fwd          = 1'b1;
          fwd_beat.sop = (pay_pos == '0);
          if (pay_pos == PAY_LAST) begin
            fwd_beat.eop = 1'b1;
            if (in_s.eop) begin
              state_d  = IDLE;
              good_sym = ~in_s.err;
            end else begin
              state_d   = DRAIN;
              len_err_d = 1'b1;
            end
          end else if (in_s.eop) begin
            fwd_beat.eop = 1'b1;
            fwd_beat.err = 1'b1;
            len_err_d    = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d   = PAYLOAD;
            pay_cnt_d = pay_pos + PW'(1);
          end
        end
        DRAIN: if (in_s.eop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry skid buffer; entry 0 is the head presented on the source.
  always_comb begin
    pop   = (cnt_q != 2'd0) & out_s.ready;
    buf_d = buf_q;
    cnt_d = cnt_q;
    case ({fwd, pop})
      2'b10: begin
        buf_d[cnt_q[0]] = fwd_beat;
        cnt_d           = cnt_q + 2'd1;
      end
      2'b01: begin
        buf_d[0] = buf_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf_d[0] = fwd_beat;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = fwd_beat;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cp_len_q  <= '0;
      cp_cnt_q  <= '0;
      pay_cnt_q <= '0;
      cnt_q     <= '0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      ready_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cp_len_q  <= cp_len_d;
      cp_cnt_q  <= cp_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      ready_q   <= (cnt_d != 2'd2);
      len_err_q <= len_err_d;
    end
  end

  assign in_s.ready  = ready_q;
  assign out_s.valid = (cnt_q != 2'd0);
  assign out_s.data  = buf_q[0].data;
  assign out_s.sop   = buf_q[0].sop;
  assign out_s.eop   = buf_q[0].eop;
  assign out_s.err   = buf_q[0].err;
  assign len_err_o   = len_err_q;

`ifdef OFDM_CP_REMOVER_STATS_EN
  logic [15:0] sym_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (good_sym && (sym_cnt_q != '1)) sym_cnt_q <= sym_cnt_q + 16'd1;
      if (len_err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign sym_cnt_o = sym_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif
endmodule

module ofdm_cp_remover #(
  parameter int DATA_W = 32,
  parameter int NFFT   = 32,
  parameter int CP_MAX = 8
) (
  input  logic                         clock_clk,
  input  logic                         reset_reset_n,
  input  logic [$clog2(CP_MAX+1)-1:0]  cfg_cp_len,
  input  logic [DATA_W-1:0]            asi_in0_data,
  input  logic                         asi_in0_valid,
  output logic                         asi_in0_ready,
  input  logic                         asi_in0_startofpacket,
  input  logic                         asi_in0_endofpacket,
  output logic [DATA_W-1:0]            aso_out0_data,
  output logic                         aso_out0_valid,
  input  logic                         aso_out0_ready,
  output logic                         aso_out0_startofpacket,
  output logic                         aso_out0_endofpacket,
  output logic                         aso_out0_error,
  output logic                         sts_len_err
`ifdef OFDM_CP_REMOVER_STATS_EN
  ,
  output logic [15:0]                  sts_sym_cnt,
  output logic [15:0]                  sts_err_cnt
`endif
);
  localparam int CPW = $clog2(CP_MAX + 1);

  ofdm_cp_remover_if #(.DATA_W(DATA_W)) in_if ();
  ofdm_cp_remover_if #(.DATA_W(DATA_W)) out_if ();

  assign in_if.data  = asi_in0_data;
  assign in_if.valid = asi_in0_valid;
  assign in_if.sop   = asi_in0_startofpacket;
  assign in_if.eop   = asi_in0_endofpacket;
  assign in_if.err   = 1'b0;
  assign asi_in0_ready = in_if.ready;

  assign out_if.ready           = aso_out0_ready;
  assign aso_out0_data          = out_if.data;
  assign aso_out0_valid         = out_if.valid;
  assign aso_out0_startofpacket = out_if.sop;
  assign aso_out0_endofpacket   = out_if.eop;
  assign aso_out0_error         = out_if.err;

  ofdm_cp_remover_core #(
    .DATA_W (DATA_W),
    .NFFT   (NFFT),
    .CP_MAX (CP_MAX),
    .CPW    (CPW)
  ) u_core (
    .clk_i        (clock_clk),
    .rst_ni       (reset_reset_n),
    .cfg_cp_len_i (cfg_cp_len),
    .in_s         (in_if),
    .out_s        (out_if),
    .len_err_o    (sts_len_err)
`ifdef OFDM_CP_REMOVER_STATS_EN
    ,
    .sym_cnt_o    (sts_sym_cnt),
    .err_cnt_o    (sts_err_cnt)
`endif
  );
endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Self-checking bench for ofdm_cp_remover: directed table, corner sequences,
// and randomized streams against a segment-level reference model.
module tb_ofdm_cp_remover;
  localparam int DW   = 32;
  localparam int NFFT = 32;
  localparam int CPM  = 8;

  typedef struct { logic [31:0] data; bit sop; bit eop; logic [3:0] cfg; } ibeat_t;
  typedef struct { logic [31:0] data; bit sop; bit eop; bit err; } obeat_t;
  typedef struct {
    logic [3:0] cfg; int len; bit rr;
    int exp_n; int exp_first; int exp_last; bit exp_eop; bit exp_err; int exp_errs;
  } row_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cfg = '0;
  logic       len_err;
`ifdef OFDM_CP_REMOVER_STATS_EN
  logic [15:0] sym_cnt, err_cnt;
`endif

  ofdm_cp_remover_if #(.DATA_W(DW)) src ();
  ofdm_cp_remover_if #(.DATA_W(DW)) snk ();

  ofdm_cp_remover #(.DATA_W(DW), .NFFT(NFFT), .CP_MAX(CPM)) dut (
    .clock_clk              (clk),
    .reset_reset_n          (rst_n),
    .cfg_cp_len             (cfg),
    .asi_in0_data           (src.data),
    .asi_in0_valid          (src.valid),
    .asi_in0_ready          (src.ready),
    .asi_in0_startofpacket  (src.sop),
    .asi_in0_endofpacket    (src.eop),
    .aso_out0_data          (snk.data),
    .aso_out0_valid         (snk.valid),
    .aso_out0_ready         (snk.ready),
    .aso_out0_startofpacket (snk.sop),
    .aso_out0_endofpacket   (snk.eop),
    .aso_out0_error         (snk.err),
    .sts_len_err            (len_err)
`ifdef OFDM_CP_REMOVER_STATS_EN
    ,
    .sts_sym_cnt            (sym_cnt),
    .sts_err_cnt            (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     errors = 0, checks = 0, cyc = 0, err_seen = 0;
  bit     rdy_rand = 1'b0;
  bit     stalled = 1'b0;
  obeat_t held;
  obeat_t got[$];
  int     out_cyc[$], acc_cyc[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint pk(input obeat_t b);
    return longint'({b.data, b.sop, b.eop, b.err});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    snk.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      snk.ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, between launches.
  always @(negedge clk) begin
    obeat_t cur;
    if (rst_n) begin
      cur = '{snk.data, snk.sop, snk.eop, snk.err};
      if (src.valid && src.ready) acc_cyc.push_back(cyc);
      if (stalled && snk.valid) check("stall_hold", pk(cur), pk(held));
      if (snk.valid && snk.ready) begin
        got.push_back(cur);
        out_cyc.push_back(cyc);
      end
      if (len_err) err_seen++;
      stalled = snk.valid && !snk.ready;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  // Segment-level reference: each SOP opens a symbol that ends at its EOP,
  // at the next SOP (restart) or at stream end; error pulses are per beat.
  function automatic void model(input ibeat_t s[$], output obeat_t e[$], output int errs);
    bit eb[int];
    int n, i, start, cp, last, len, npay;
    bit cut, eop_term;
    obeat_t b;
    e.delete();
    n = s.size();
    i = 0;
    while (i < n) begin
      if (!s[i].sop) begin
        i++;
        continue;
      end
      start = i;
      cp    = (int'(s[i].cfg) > CPM) ? CPM : int'(s[i].cfg);
      last  = n - 1;
      cut   = 1'b0;
      for (int k = start; k < n; k++) begin
        if (k > start && s[k].sop) begin last = k - 1; cut = 1'b1; break; end
        if (s[k].eop) begin last = k; break; end
      end
      len      = last - start + 1;
      eop_term = s[last].eop;
      npay     = len - cp;
      if (npay > NFFT) npay = NFFT;
      if (npay < 0) npay = 0;
      for (int j = 0; j < npay; j++) begin
        b = '{s[start + cp + j].data, (j == 0), 1'b0, 1'b0};
        e.push_back(b);
      end
      if (len >= cp + NFFT) begin
        e[e.size() - 1].eop = 1'b1;
        if (!(len == cp + NFFT && eop_term)) eb[start + cp + NFFT - 1] = 1'b1;
      end else if (eop_term) begin
        eb[last] = 1'b1;
        if (npay > 0) begin
          e[e.size() - 1].eop = 1'b1;
          e[e.size() - 1].err = 1'b1;
        end
      end
      if (cut) eb[last + 1] = 1'b1;
      i = last + 1;
    end
    errs = eb.num();
  endfunction

  function automatic void gen(output ibeat_t s[$], input int nseg, input bit clean,
                              input logic [3:0] fixed_cfg);
    bit prev_cut = 1'b0, term_cut;
    logic [3:0] c;
    int cp, len, r;
    ibeat_t b;
    s.delete();
    for (int g = 0; g < nseg; g++) begin
      if (!clean && !prev_cut && $urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
          b = '{$urandom, 1'b0, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15))};
          s.push_back(b);
        end
      end
      c  = clean ? fixed_cfg : 4'($urandom_range(0, 15));
      cp = (int'(c) > CPM) ? CPM : int'(c);
      r  = $urandom_range(0, 9);
      if (clean || r < 5) len = cp + NFFT;
      else if (r < 8)     len = $urandom_range(1, cp + NFFT + 6);
      else                len = cp + NFFT + $urandom_range(1, 5);
      term_cut = !clean && (g != nseg - 1) && ($urandom_range(0, 9) == 0);
      for (int j = 0; j < len; j++) begin
        b = '{$urandom, (j == 0), (j == len - 1) && !term_cut, c};
        s.push_back(b);
      end
      prev_cut = term_cut;
    end
  endfunction

  task automatic drive(input ibeat_t s[$], input int gap_pct);
    bit acc;
    int budget;
    foreach (s[i]) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        src.valid = 1'b0;
        @(posedge clk);
        #1;
      end
      src.valid = 1'b1;
      src.data  = s[i].data;
      src.sop   = s[i].sop;
      src.eop   = s[i].eop;
      cfg       = s[i].cfg;
      budget    = 0;
      do begin
        @(negedge clk);
        acc = src.ready;
        @(posedge clk);
        #1;
        budget++;
      end while (!acc && budget < 200);
      if (!acc) check("in_ready_timeout", 0, 1);
    end
    src.valid = 1'b0;
    src.sop   = 1'b0;
    src.eop   = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int b = 0;
    while ((got.size() < n || snk.valid) && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 3000) check("drain_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got.delete();
    out_cyc.delete();
    acc_cyc.delete();
    err_seen = 0;
  endtask

  task automatic compare_seq(input string name, input obeat_t e[$], input int me);
    int m;
    check({name, "_len"}, got.size(), e.size());
    m = (got.size() < e.size()) ? got.size() : e.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_beat%0d", name, i), pk(got[i]), pk(e[i]));
    check({name, "_errs"}, err_seen, me);
  endtask

  initial begin
    row_t   rows[8];
    ibeat_t s[$], s2[$];
    obeat_t e[$];
    ibeat_t b;
    int     me;

    rows[0] = '{4'd4,  36, 1'b0, 32, 4, 35, 1'b1, 1'b0, 0};
    rows[1] = '{4'd0,  32, 1'b0, 32, 0, 31, 1'b1, 1'b0, 0};
    rows[2] = '{4'd15, 40, 1'b0, 32, 8, 39, 1'b1, 1'b0, 0};
    rows[3] = '{4'd4,   3, 1'b0,  0, 0,  0, 1'b0, 1'b0, 1};
    rows[4] = '{4'd4,  21, 1'b0, 17, 4, 20, 1'b1, 1'b1, 1};
    rows[5] = '{4'd4,  40, 1'b0, 32, 4, 35, 1'b1, 1'b0, 1};
    rows[6] = '{4'd1,  33, 1'b1, 32, 1, 32, 1'b1, 1'b0, 0};
    rows[7] = '{4'd8,   9, 1'b0,  1, 8,  8, 1'b1, 1'b1, 1};

    src.valid = 1'b0; src.data = '0; src.sop = 1'b0; src.eop = 1'b0; src.err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", snk.valid, 0);
    check("rst_in_ready", src.ready, 0);
    check("rst_out_data", snk.data, 0);
    check("rst_out_flags", {snk.sop, snk.eop, snk.err}, 0);
    check("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_deassert", src.ready, 0);
    @(posedge clk);
    #1;
    check("ready_one_cycle_later", src.ready, 1);

    for (int r = 0; r < 8; r++) begin
      rdy_rand = rows[r].rr;
      clear();
      s.delete();
      for (int j = 0; j < rows[r].len; j++) begin
        b = '{32'(j), (j == 0), (j == rows[r].len - 1), rows[r].cfg};
        s.push_back(b);
      end
      model(s, e, me);
      drive(s, 0);
      wait_drain(rows[r].exp_n);
      check($sformatf("row%0d_n", r), got.size(), rows[r].exp_n);
      check($sformatf("row%0d_errs", r), err_seen, rows[r].exp_errs);
      if (rows[r].exp_n > 0 && got.size() == rows[r].exp_n) begin
        check($sformatf("row%0d_first", r), got[0].data, rows[r].exp_first);
        check($sformatf("row%0d_last", r), got[got.size()-1].data, rows[r].exp_last);
        check($sformatf("row%0d_last_eop", r), got[got.size()-1].eop, rows[r].exp_eop);
        check($sformatf("row%0d_last_err", r), got[got.size()-1].err, rows[r].exp_err);
        if (!rows[r].rr && rows[r].exp_n == NFFT) begin
          check($sformatf("row%0d_no_gaps", r), out_cyc[NFFT-1] - out_cyc[0], NFFT - 1);
          check($sformatf("row%0d_latency", r), out_cyc[0] - acc_cyc[rows[r].exp_first], 1);
        end
      end
      compare_seq($sformatf("row%0d_model", r), e, me);
    end

    // Ten clean symbols under 50% output back-pressure.
    rdy_rand = 1'b1;
    clear();
    gen(s, 10, 1'b1, 4'd4);
    model(s, e, me);
    drive(s, 20);
    wait_drain(e.size());
    check("stall10_n", got.size(), 10 * NFFT);
    compare_seq("stall10", e, me);

    // Randomized framing, lengths, restarts and junk beats.
    for (int k = 0; k < 3; k++) begin
      clear();
      gen(s, 8, 1'b0, 4'd0);
      model(s, e, me);
      drive(s, 25);
      wait_drain(e.size());
      compare_seq($sformatf("rand%0d", k), e, me);
    end

    // SOP+EOP beat arriving in PAYLOAD: restart and CP-skip EOP coincide.
    rdy_rand = 1'b0;
    clear();
    s.delete();
    for (int j = 0; j < 20; j++) begin
      b = '{32'(j), (j == 0), 1'b0, 4'd4};
      s.push_back(b);
    end
    b = '{32'd99, 1'b1, 1'b1, 4'd4};
    s.push_back(b);
    model(s, e, me);
    drive(s, 0);
    wait_drain(16);
    check("coinc_n", got.size(), 16);
    check("coinc_errs", err_seen, 1);
    compare_seq("coinc", e, me);

    // Restart in PAYLOAD with cp_len=0: next forwarded beat carries SOP.
    clear();
    s.delete();
    for (int j = 0; j < 20; j++) begin
      b = '{32'(j), (j == 0), 1'b0, 4'd4};
      s.push_back(b);
    end
    for (int j = 0; j < NFFT; j++) begin
      b = '{32'(200 + j), (j == 0), (j == NFFT - 1), 4'd0};
      s.push_back(b);
    end
    model(s, e, me);
    drive(s, 0);
    wait_drain(16 + NFFT);
    check("restart_n", got.size(), 16 + NFFT);
    if (got.size() > 16) begin
      check("restart_sop", got[16].sop, 1);
      check("restart_data", got[16].data, 200);
    end
    compare_seq("restart", e, me);

    // Reset at beat 10 of a symbol, then one clean symbol.
    clear();
    s.delete();
    for (int j = 0; j < 10; j++) begin
      b = '{32'(j), (j == 0), 1'b0, 4'd4};
      s.push_back(b);
    end
    drive(s, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear();
    check("midrst_out_valid", snk.valid, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_low", src.ready, 0);
    @(posedge clk);
    #1;
    check("midrst_ready_high", src.ready, 1);
    s2.delete();
    for (int j = 0; j < 4 + NFFT; j++) begin
      b = '{32'(100 + j), (j == 0), (j == 3 + NFFT), 4'd4};
      s2.push_back(b);
    end
    model(s2, e, me);
    drive(s2, 0);
    wait_drain(NFFT);
    check("midrst_n", got.size(), NFFT);
    if (got.size() > 0) check("midrst_first", got[0].data, 104);
    compare_seq("midrst", e, me);
`ifdef OFDM_CP_REMOVER_STATS_EN
    check("midrst_sym_cnt", sym_cnt, 1);
    check("midrst_err_cnt", err_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
